apb_master_arbiter: RTL
=======================

Name: apb_master_arbiter

Overview:
- Round-robin arbiter plus APB master sequencer; shares one APB slave port among NUM_REQ local requesters.
- Latches the winning request and drives the psel/penable/paddr/pwrite/pwdata protocol.
- Returns prdata/pslverr to the requester that was granted.
- Sits upstream of the APB slave wrapper; the only block driving its bus.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- addrWidth, 32, APB address width.
- dataWidth, 32, APB data width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until the matching req_done.
- req_write  in  NUM_REQ  per-requester direction; 1 = write.
- req_addr  in  NUM_REQ*addrWidth  packed addresses; requester i at [i*addrWidth +: addrWidth].
- req_wdata  in  NUM_REQ*dataWidth  packed write data; same packing.
- req_gnt  out  NUM_REQ  one-hot; high from grant through completion.
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse on completion.
- resp_rdata  out  dataWidth  read data; valid with req_done.
- resp_err  out  1  error flag; valid with req_done.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  addrWidth  APB address.
- pwdata  out  dataWidth  APB write data.
- pready  in  1  APB ready.
- prdata  in  dataWidth  APB read data.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (sync, rst=1 at a pclk edge):
  - FSM goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, req_gnt, req_done, resp_rdata, resp_err all go to 0.
  - RR pointer goes to 0.
  - Reset beats everything. An in-flight transfer is dropped and no req_done is pulsed.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - If any req_valid is set, pick the winner: the first set bit at or after the RR pointer, searching upward with wrap.
  - Latch the winner's addr/write/wdata into paddr/pwrite/pwdata.
  - Set req_gnt[winner], go to SETUP.
  - In SETUP: psel=1, penable=0.
- SETUP: unconditionally go to ACCESS (psel=1, penable=1).
- ACCESS, pready=0: stay; hold all bus outputs stable.
- ACCESS, pready=1, at that edge:
  - Capture resp_rdata = prdata on reads, 0 on writes.
  - Capture resp_err = pslverr.
  - Pulse req_done[winner].
  - Clear req_gnt.
  - Set RR pointer = winner+1 modulo NUM_REQ.
- Back-to-back: on the completion edge, arbitrate again. The finishing requester's req_valid is masked for that edge, since it is still held high.
  - Other requester valid: go straight to SETUP with psel staying 1, penable going 0, the new winner latched and its req_gnt set.
  - No other requester valid: go to IDLE, psel=0, penable=0.
- Latency, uncontended request seen in IDLE at edge 0:
  - SETUP from edge 1, ACCESS from edge 2.
  - Zero-wait slave: req_done is high in the cycle after edge 3.
  - Each pready wait state adds one cycle.
- req_valid dropping after grant is ignored: the transfer completes and req_done still pulses.
- req_valid dropping before grant withdraws the request.
- Simultaneous requests resolve by RR order only. No starvation: any continuously held request is served within NUM_REQ transfers.
- paddr and pwdata keep their last values in IDLE. pwrite=0 in IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES without pready, abort: req_done pulses with resp_err=1 and resp_rdata=0.
  - psel and penable drop, or go to SETUP for the next winner; the RR pointer advances normally.
- Undefined: no counter; ACCESS waits for pready indefinitely.

Test Plan:
- Single write: req_valid=4'b0001, addr 0x10, wdata 0xA5A5_0001, pready tied 1 -> psel high 2 cycles, penable high in the 2nd; paddr=0x10, pwdata=0xA5A5_0001; req_done=4'b0001 with resp_err=0; then IDLE.
- Read with 3 wait states: requester 2 reads 0x44, pready rises on the 4th ACCESS cycle with prdata=0xDEAD_BEEF -> req_done=4'b0100, resp_rdata=0xDEAD_BEEF, ACCESS lasted 4 cycles.
- Contention: all four req_valid high from reset, held, zero-wait slave -> grants 0,1,2,3,0 in order; psel stays 1 between transfers; one transfer per 2 cycles.
- Error: pslverr=1 together with pready on a write -> resp_err=1 for that req_done only; next transfer has resp_err=0.
- Reset mid-ACCESS: rst=1 for 1 cycle while pready=0 -> next cycle psel=0, penable=0, req_gnt=0, no req_done; RR pointer=0.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16, pready tied 0 -> req_done after 16 ACCESS cycles with resp_err=1 and resp_rdata=0; bus returns to IDLE.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter feeding a single APB master sequencer (IDLE/SETUP/ACCESS).
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int addrWidth      = 32,
    parameter int dataWidth      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*addrWidth-1:0]   req_addr,
    input  logic [NUM_REQ*dataWidth-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             req_gnt,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [dataWidth-1:0]           resp_rdata,
    output logic                           resp_err,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [addrWidth-1:0]           paddr,
    output logic [dataWidth-1:0]           pwdata,
    input  logic                           pready,
    input  logic [dataWidth-1:0]           prdata,
    input  logic                           pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]        cur_idx, cur_idx_n;
    logic [NUM_REQ-1:0]      req_gnt_n, req_done_n;
    logic [dataWidth-1:0]    resp_rdata_n;
    logic                    resp_err_n;
    logic                    psel_n, penable_n, pwrite_n;
    logic [addrWidth-1:0]    paddr_n;
    logic [dataWidth-1:0]    pwdata_n;

    logic                    arb_go;
    logic [IDX_W-1:0]        arb_ptr;
    logic [NUM_REQ-1:0]      arb_mask;
    logic [IDX_W:0]          pick;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cur_next;
    logic                    tmo_hit;

    // First set bit at or above ptr, wrapping; MSB of the result flags "found".
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (vec[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    assign cur_next = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;

    assign tmo_hit = (state == ACCESS) && !pready &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_n = tmo_cnt;
        if (state == SETUP) begin
            tmo_cnt_n = '0;
        end else if (state == ACCESS && !pready && !tmo_hit) begin
            tmo_cnt_n = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_n;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        cur_idx_n    = cur_idx;
        req_gnt_n    = req_gnt;
        req_done_n   = '0;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        psel_n       = psel;
        penable_n    = penable;
        pwrite_n     = pwrite;
        paddr_n      = paddr;
        pwdata_n     = pwdata;
        arb_go       = 1'b0;
        arb_ptr      = rr_ptr;
        arb_mask     = '1;

        case (state)
            IDLE: begin
                arb_go = 1'b1;
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            ACCESS: begin
                if (pready || tmo_hit) begin
                    req_done_n        = NUM_REQ'(1) << cur_idx;
                    resp_rdata_n      = (pready && !pwrite) ? prdata : '0;
                    resp_err_n        = pready ? pslverr : 1'b1;
                    req_gnt_n         = '0;
                    rr_ptr_n          = cur_next;
                    // The finisher still holds req_valid this edge; keep it out of the race.
                    arb_go            = 1'b1;
                    arb_ptr           = cur_next;
                    arb_mask[cur_idx] = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        pick    = rr_pick(req_valid & arb_mask, arb_ptr);
        win_idx = pick[IDX_W-1:0];

        if (arb_go) begin
            if (pick[IDX_W]) begin
                state_n   = SETUP;
                cur_idx_n = win_idx;
                req_gnt_n = NUM_REQ'(1) << win_idx;
                psel_n    = 1'b1;
                penable_n = 1'b0;
                pwrite_n  = req_write[win_idx];
                paddr_n   = req_addr[win_idx*addrWidth +: addrWidth];
                pwdata_n  = req_wdata[win_idx*dataWidth +: dataWidth];
            end else begin
                state_n   = IDLE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
                pwrite_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_idx    <= '0;
            req_gnt    <= '0;
            req_done   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            cur_idx    <= cur_idx_n;
            req_gnt    <= req_gnt_n;
            req_done   <= req_done_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            psel       <= psel_n;
            penable    <= penable_n;
            pwrite     <= pwrite_n;
            paddr      <= paddr_n;
            pwdata     <= pwdata_n;
        end
    end

endmodule
